// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with snapshot shadows.
// Ports: clk, reset (async, active-low), count_event, enable, freeze,
//   clear, snap, rd_sel in; data_out (shadow[rd_sel]), ovf, snap_valid out.
module perf_counter_bank #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 10,
  parameter int EDGE_MODE = 1,
  parameter int SATURATE  = 0,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] count_event,
  input  logic [NUM_CH-1:0] enable,
  input  logic              freeze,
  input  logic              clear,
  input  logic              snap,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [WIDTH-1:0]  data_out,
  output logic [NUM_CH-1:0] ovf,
  output logic              snap_valid
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] go;
  logic [WIDTH-1:0]  cnt    [NUM_CH];
  logic [WIDTH-1:0]  shadow [NUM_CH];

  always_comb begin
    inc = (EDGE_MODE != 0) ? (count_event & ~prev)
                           : count_event;
    go  = inc & enable & {NUM_CH{~freeze & ~clear}};
  end

  // prev tracks the raw input even when gated, so a level
  // held across a freeze or disable is not seen as a new edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev       <= '0;
      ovf        <= '0;
      snap_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      prev       <= clear ? '0 : count_event;
      snap_valid <= snap;
      for (int i = 0; i < NUM_CH; i++) begin
        if (snap)
          shadow[i] <= cnt[i];
        if (clear) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (go[i]) begin
          if (cnt[i] == MAX) begin
            ovf[i] <= 1'b1;
            cnt[i] <= (SATURATE != 0) ? MAX : '0;
          end else begin
            cnt[i] <= cnt[i] + WIDTH'(1);
          end
        end
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (int'(rd_sel) == i)
        data_out = shadow[i];
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: two configurations of perf_counter_bank
// driven in parallel and checked against a behavioural model.
module tb_perf_counter_bank;

  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count_event = '0;
  logic [3:0] enable = '0;
  logic       freeze = 1'b0;
  logic       clear = 1'b0;
  logic       snap = 1'b0;
  logic [1:0] rd_sel = '0;

  logic [3:0] dout0, dout1;
  logic [3:0] ovf0;
  logic [2:0] ovf1;
  logic       sv0, sv1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // edge counting, wrap
  perf_counter_bank #(
    .NUM_CH(4), .WIDTH(4), .EDGE_MODE(1), .SATURATE(0)
  ) u0 (
    .clk(clk), .reset(reset),
    .count_event(count_event), .enable(enable),
    .freeze(freeze), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .data_out(dout0),
    .ovf(ovf0), .snap_valid(sv0)
  );

  // level counting, saturate, non power-of-two channels
  perf_counter_bank #(
    .NUM_CH(3), .WIDTH(4), .EDGE_MODE(0), .SATURATE(1)
  ) u1 (
    .clk(clk), .reset(reset),
    .count_event(count_event[2:0]), .enable(enable[2:0]),
    .freeze(freeze), .clear(clear), .snap(snap),
    .rd_sel(rd_sel), .data_out(dout1),
    .ovf(ovf1), .snap_valid(sv1)
  );

  // ---------------- behavioural model ----------------
  int mcnt [2][4];
  int msh  [2][4];
  bit movf [2][4];
  bit mprev [4];
  bit msv;

  function automatic int nch(int c);
    return (c == 0) ? 4 : 3;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      msv = 0;
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 4; i++) begin
          mcnt[c][i] = 0;
          msh[c][i] = 0;
          movf[c][i] = 0;
          mprev[i] = 0;
        end
    end else begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < nch(c); i++) begin
          bit hit;
          hit = (c == 0) ? (count_event[i] && !mprev[i])
                         : count_event[i];
          if (snap) msh[c][i] = mcnt[c][i];
          if (clear) begin
            mcnt[c][i] = 0;
            movf[c][i] = 0;
          end else if (hit && enable[i] && !freeze) begin
            if (mcnt[c][i] + 1 > MAXV) movf[c][i] = 1;
            if (c == 1)
              mcnt[c][i] = (mcnt[c][i] + 1 > MAXV)
                           ? MAXV : mcnt[c][i] + 1;
            else
              mcnt[c][i] = (mcnt[c][i] + 1) % (MAXV + 1);
          end
        end
      msv = snap;
      for (int i = 0; i < 4; i++)
        mprev[i] = clear ? 1'b0 : count_event[i];
    end
  end

  function automatic int movf_vec(int c);
    int v = 0;
    for (int i = 0; i < nch(c); i++)
      if (movf[c][i]) v |= (1 << i);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s got=%0d want=%0d t=%0t",
                  name, act, exp, $time);
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("dout0", int'(dout0), msh[0][rd_sel]);
    chk("dout1", int'(dout1),
        (rd_sel < 3) ? msh[1][rd_sel] : 0);
    chk("ovf0", int'(ovf0), movf_vec(0));
    chk("ovf1", int'(ovf1), movf_vec(1));
    chk("sv0", int'(sv0), int'(msv));
    chk("sv1", int'(sv1), int'(msv));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(int ch, int n);
    for (int k = 0; k < n; k++) begin
      count_event[ch] = 1'b1;
      tick();
      count_event[ch] = 1'b0;
      tick();
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_snap(int sel);
    rd_sel = 2'(sel);
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  initial begin
    // reset held while inputs toggle
    enable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      count_event = 4'($urandom);
      snap = 1'($urandom);
      tick();
    end
    count_event = '0;
    snap = 1'b0;
    tick();
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rd_sel = 2'(s);
      tick();
      chk("idle_dout0", int'(dout0), 0);
      chk("idle_dout1", int'(dout1), 0);
      chk("idle_ovf0", int'(ovf0), 0);
      chk("idle_sv0", int'(sv0), 0);
    end

    // ch0: high 5, low 2, high 3, low 1
    count_event[0] = 1'b1; repeat (5) tick();
    count_event[0] = 1'b0; repeat (2) tick();
    count_event[0] = 1'b1; repeat (3) tick();
    count_event[0] = 1'b0; tick();
    do_snap(0);
    chk("edge_cnt", int'(dout0), 2);
    chk("level_cnt", int'(dout1), 8);
    chk("edge_model", msh[0][0], 2);
    chk("level_model", msh[1][0], 8);
    chk("snap_valid_hi", int'(sv0), 1);
    tick();
    chk("snap_valid_lo", int'(sv0), 0);

    // 17 single-cycle events on ch1
    do_clear();
    pulse(1, 17);
    do_snap(1);
    chk("wrap_dout", int'(dout0), 1);
    chk("sat_dout", int'(dout1), 15);
    chk("wrap_ovf", int'(ovf0[1]), 1);
    chk("sat_ovf", int'(ovf1[1]), 1);
    chk("wrap_model", msh[0][1], 1);

    // clear wins over a same-cycle edge
    do_clear();
    pulse(2, 7);
    do_snap(2);
    chk("pre_clr0", int'(dout0), 7);
    chk("pre_clr1", int'(dout1), 7);
    count_event[2] = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_event[2] = 1'b0;
    tick();
    do_snap(2);
    chk("clr_cnt0", int'(dout0), 0);
    chk("clr_cnt1", int'(dout1), 0);
    chk("clr_ovf0", int'(ovf0), 0);
    pulse(2, 1);
    do_snap(2);
    chk("post_clr0", int'(dout0), 1);
    chk("post_clr1", int'(dout1), 1);

    // snapshot coherence and back-to-back snaps
    do_clear();
    pulse(0, 3);
    rd_sel = 2'd0;
    count_event[0] = 1'b1;
    snap = 1'b1;
    tick();
    count_event[0] = 1'b0;
    chk("coh_shadow0", int'(dout0), 3);
    chk("coh_shadow1", int'(dout1), 3);
    chk("coh_sv", int'(sv0), 1);
    tick();
    chk("b2b_live0", int'(dout0), 4);
    chk("b2b_live1", int'(dout1), 4);
    chk("b2b_sv", int'(sv1), 1);
    snap = 1'b0;
    tick();
    chk("b2b_sv_end", int'(sv0), 0);

    // gating by enable and freeze
    do_clear();
    enable = 4'b1011;
    pulse(2, 4);
    enable = 4'hF;
    freeze = 1'b1;
    pulse(2, 4);
    count_event[2] = 1'b1;
    tick();
    freeze = 1'b0;
    repeat (2) tick();
    count_event[2] = 1'b0;
    tick();
    do_snap(2);
    chk("gate_edge", int'(dout0), 0);
    chk("gate_level", int'(dout1), 2);
    rd_sel = 2'd3;
    #1;
    chk("sel_oob", int'(dout1), 0);

    // randomized traffic with one mid-run async reset
    for (int k = 0; k < 3000; k++) begin
      count_event = 4'($urandom);
      enable = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      freeze = ($urandom_range(7) == 0);
      clear = ($urandom_range(49) == 0);
      snap = ($urandom_range(5) == 0);
      rd_sel = 2'($urandom);
      if (k == 1500) begin
        #2 reset = 1'b0;
        tick();
        #2 reset = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised multi-channel successor to the single 10-bit event counter. It counts events on NUM_CH independent channels, with selectable edge or level counting and wrap or saturate on overflow. A synchronous clear takes priority over counting. A snapshot copies all live counters into shadow registers, so software reads a coherent set through one muxed read port. The block sits beside the pipeline and collects stall, flush, miss and retire statistics.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
WIDTH, 10, counter width in bits (2..32)
EDGE_MODE, 1, 1 = count 0->1 transitions of count_event; 0 = count every cycle count_event is high
SATURATE, 0, 1 = hold at all-ones on overflow; 0 = wrap to zero
SEL_W, max(1,$clog2(NUM_CH)), width of rd_sel (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
count_event  in  NUM_CH  per-channel raw event inputs, synchronous to clk
enable  in  NUM_CH  per-channel count enable
freeze  in  1  global hold; no channel increments while high
clear  in  1  synchronous clear of all counters, overflow flags and edge history
snap  in  1  one-cycle pulse; capture all live counters into shadow registers
rd_sel  in  SEL_W  shadow channel select for data_out
data_out  out  WIDTH  shadow[rd_sel], combinational from shadow registers
ovf  out  NUM_CH  sticky per-channel overflow flags (live)
snap_valid  out  1  high for exactly one cycle after a snap capture

Behaviour:
- Reset (reset=0, asynchronous): all counters, shadows, ovf, edge-history regs and snap_valid go to 0. Hence data_out=0.
- Per-channel increment term inc[i]:
  - EDGE_MODE=1: inc[i] = count_event[i] & ~prev[i]. prev[i] registers count_event[i] every cycle, including while frozen or disabled, so a level held across a freeze is not recounted.
  - EDGE_MODE=0: inc[i] = count_event[i].
- Increment condition: inc[i] & enable[i] & ~freeze & ~clear.
- Count priority per cycle: clear > increment > hold. clear zeroes count[i] and ovf[i] and sets prev[i] to 0. An event edge in the same cycle as clear is dropped.
- Overflow, when incrementing at count=all-ones:
  - SATURATE=0: count wraps to 0 and ovf[i] is set.
  - SATURATE=1: count stays at all-ones and ovf[i] is set.
  - ovf stays set until clear or reset.
- Snapshot:
  - On a snap cycle, shadow[i] <= count[i], the pre-update value of that same edge. An increment or clear in the same cycle is not reflected in the shadow.
  - snap_valid asserts in the following cycle for one cycle. Back-to-back snaps give snap_valid high on consecutive cycles.
- Read: data_out = shadow[rd_sel] combinationally. rd_sel >= NUM_CH returns 0.
- Latency:
  - Event to live count: 1 cycle in level mode.
  - Event to live count: 1 cycle after the rising edge in edge mode; the edge is detected on the first cycle high.
  - Live count to data_out: requires a snap; valid from the cycle snap_valid is high.
- Counters are independent; all channels may increment in the same cycle.
- Arithmetic is unsigned WIDTH-bit. No carry outside ovf.
- Reset deasserted mid-operation: counting resumes on the first clk edge with reset=1.

Test Plan:
- Reset and idle: hold reset=0 with count_event toggling, release, no events -> data_out=0, ovf=0, snap_valid=0 on every rd_sel.
- Edge counting: EDGE_MODE=1, ch0 high 5 cycles, low 2, high 3, enable=all, then snap -> shadow[0]=2. Repeat with EDGE_MODE=0 -> shadow[0]=8.
- Wrap vs saturate:
  - WIDTH=4, SATURATE=0, 17 edges on ch1, snap -> data_out=1 with rd_sel=1, ovf[1]=1.
  - SATURATE=1, same stimulus -> data_out=15, ovf[1]=1.
- Clear priority: counter at 7, edge and clear in the same cycle -> count=0, ovf=0. The next edge gives count=1.
- Snap coherence: snap in the same cycle as an increment from 3 -> shadow=3, live=4. snap_valid is high exactly the next cycle. Back-to-back snaps -> snap_valid high 2 cycles.
- Gating: enable[2]=0 or freeze=1 during 4 edges on ch2 -> count unchanged. A level held across the freeze release is not counted (EDGE_MODE=1). rd_sel=NUM_CH -> data_out=0.
